// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//
// Branch-resolution stage that sits directly after the execute ALU. Each
// accepted beat carries the ALU result plus the {OF, SF, CF, ZF} flags of an
// rs1 - rs2 subtract. The stage evaluates the branch condition, computes the
// branch target and the error/redirect outcome at the input, and stores the
// finished outcome with the beat. A two-entry skid buffer (output register +
// skid register) keeps one beat per cycle flowing under back-pressure.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       upstream beat present
//   in_ready       stage can accept (low only while both entries are full)
//   in_result      ALU result, passed through unchanged
//   in_flags       {OF, SF, CF, ZF}; CF = 1 means borrow (rs1 <u rs2)
//   in_is_branch   beat is a conditional branch
//   in_funct3      branch condition code
//   in_pc          instruction PC
//   in_imm         sign-extended B-immediate
//   flush          synchronous kill of every buffered beat
//   out_valid      output beat present
//   out_ready      downstream accepts
//   out_result     stored in_result
//   out_taken      branch condition true and encoding legal
//   out_target     in_pc + in_imm, wrapping modulo 2^WIDTH
//   out_redirect   valid, taken and word-aligned target
//   out_misaligned taken branch whose target[1:0] != 0
//   out_illegal    branch with reserved funct3 (010 / 011)
//
// Every out_* is driven from registers only; no in_* reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module branch_resolve #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_flags,
    input  logic             in_is_branch,
    input  logic [2:0]       in_funct3,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_imm,

    input  logic             flush,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_taken,
    output logic [WIDTH-1:0] out_target,
    output logic             out_redirect,
    output logic             out_misaligned,
    output logic             out_illegal
);

    // -------------------------------------------------------------------------
    // Types and encodings
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,   // nothing buffered
        S_ONE   = 2'd1,   // output register full, skid empty
        S_FULL  = 2'd2    // output and skid registers both full
    } state_t;

    // Fully resolved beat, exactly as it is presented downstream.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] target;
        logic             taken;
        logic             redirect;
        logic             misaligned;
        logic             illegal;
    } beat_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // -------------------------------------------------------------------------
    // Input-side resolution
    // -------------------------------------------------------------------------
    logic  flag_of;
    logic  flag_sf;
    logic  flag_cf;
    logic  flag_zf;
    logic  cond_true;
    logic  cond_legal;
    logic  target_unaligned;
    logic  in_taken;
    beat_t in_beat;

    assign flag_of = in_flags[3];
    assign flag_sf = in_flags[2];
    assign flag_cf = in_flags[1];
    assign flag_zf = in_flags[0];

    // NOTE: every signal written in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        cond_true  = 1'b0;
        cond_legal = 1'b1;
        unique case (in_funct3)
            F3_BEQ:  cond_true = flag_zf;
            F3_BNE:  cond_true = !flag_zf;
            F3_BLT:  cond_true = flag_sf ^ flag_of;
            F3_BGE:  cond_true = !(flag_sf ^ flag_of);
            F3_BLTU: cond_true = flag_cf;
            F3_BGEU: cond_true = !flag_cf;
            default: cond_legal = 1'b0;   // 010 / 011 are reserved
        endcase
    end

    always_comb begin
        in_beat        = '0;
        in_beat.result = in_result;
        // Wraps silently; an address overflow is not an error for branches.
        in_beat.target = in_pc + in_imm;

        target_unaligned = |in_beat.target[1:0];
        in_taken         = in_is_branch & cond_true & cond_legal;

        // Non-branch beats leave every outcome bit at zero.
        in_beat.taken      = in_taken;
        in_beat.illegal    = in_is_branch & !cond_legal;
        // Misalignment wins over redirect: fetch must never see a bad target.
        in_beat.misaligned = in_taken & target_unaligned;
        in_beat.redirect   = in_taken & !target_unaligned;
    end

    // -------------------------------------------------------------------------
    // Skid-buffer control
    // -------------------------------------------------------------------------
    state_t state;
    state_t next_state;
    logic   accept;
    logic   drain;
    logic   load_out;
    logic   load_skid;
    logic   out_from_skid;

    // Both handshakes come from registered state, so in_ready and out_valid
    // carry no combinational path from the inputs.
    assign in_ready  = (state != S_FULL);
    assign out_valid = (state != S_EMPTY);

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;

        unique case (state)
            S_EMPTY: begin
                if (accept) begin
                    next_state = S_ONE;
                    load_out   = 1'b1;
                end
            end

            S_ONE: begin
                unique case ({accept, drain})
                    2'b10: begin            // fill the skid behind the head
                        next_state = S_FULL;
                        load_skid  = 1'b1;
                    end
                    2'b01: begin            // head leaves, nothing follows
                        next_state = S_EMPTY;
                    end
                    2'b11: begin            // stream through: replace head
                        load_out   = 1'b1;
                    end
                    default: begin
                        next_state = S_ONE;
                    end
                endcase
            end

            S_FULL: begin
                // in_ready is low here, so accept cannot be set.
                if (drain) begin
                    next_state    = S_ONE;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end

            default: begin
                next_state = S_EMPTY;
            end
        endcase

        // Flush overrides everything, including a beat offered this cycle.
        if (flush) begin
            next_state = S_EMPTY;
            load_out   = 1'b0;
            load_skid  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Beat storage
    // -------------------------------------------------------------------------
    beat_t out_q;
    beat_t skid_q;

    // NOTE: the two beat registers are reset as well as the state, because
    // the output data and flags must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= out_from_skid ? skid_q : in_beat;
            end
            if (load_skid) begin
                skid_q <= in_beat;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_result     = out_q.result;
    assign out_target     = out_q.target;
    assign out_taken      = out_q.taken;
    assign out_misaligned = out_q.misaligned;
    assign out_illegal    = out_q.illegal;
    // Stale contents stay in out_q after a drain, so qualify with out_valid.
    assign out_redirect   = out_valid & out_q.redirect;

endmodule
